// File: rtl/par2ser_pkg.sv
// -----------------------------------------------------------------------------
// par2ser_pkg
// Shared types and constants for the parallel-to-serial transmitter and the
// matching receiver.
//   state_t        : frame-level FSM states
//   PAR_NONE/EVEN/ODD : encodings of the PARITY parameter
//   cnt_width()    : counter width for a modulus, never below one bit
// -----------------------------------------------------------------------------
package par2ser_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Width needed to count 0..n-1. A modulus of 1 still gets a 1-bit counter
  // so that no zero-width vectors are declared.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : par2ser_pkg

// File: rtl/ser_bit_tick.sv
// -----------------------------------------------------------------------------
// ser_bit_tick
// Bit-period divider. While run is high it counts 0..CLK_DIV-1 and raises
// tick on the final count of each bit period; while run is low the counter is
// held at zero so every new frame begins on a clean bit boundary.
//
// Ports
//   sys_clk : clock, rising edge
//   sys_rst : synchronous reset, active-high
//   run     : frame in progress (driven from registered state)
//   tick    : high on the last cycle of the current bit period
// -----------------------------------------------------------------------------
module ser_bit_tick
  import par2ser_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic run,
  output logic tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("ser_bit_tick: CLK_DIV must be at least 1");
  end

  logic [CW-1:0] div_cnt;

  // With CLK_DIV = 1 the counter is stuck at zero and tick follows run.
  assign tick = run && (div_cnt == DIV_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !run) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule : ser_bit_tick

// File: rtl/par2ser_tx.sv
// -----------------------------------------------------------------------------
// par2ser_tx
// Parallel-to-serial transmitter. Accepts a WIDTH-bit word over a
// valid/ready handshake and sends it as
//   start (0) | WIDTH data bits | optional parity | stop (1)
// with every bit held for CLK_DIV clock cycles. The line idles high.
//
// Parameters
//   WIDTH     : data bits per frame (>= 1)
//   CLK_DIV   : clock cycles per serial bit (>= 1)
//   LSB_FIRST : 1 = bit 0 first, 0 = bit WIDTH-1 first
//   PARITY    : 0 none, 1 even, 2 odd
//
// Ports
//   sys_clk    : clock, rising edge
//   sys_rst    : synchronous reset, active-high
//   in_data    : parallel word from upstream
//   in_valid   : in_data valid; upstream holds it until accepted
//   in_ready   : high in IDLE, word accepted on in_valid & in_ready
//   ser_out    : serial line
//   ser_busy   : frame in progress
//   frame_done : one-cycle pulse on the last cycle of the stop bit
//
// Every output is decoded from registered state only, so there is no
// combinational path from in_valid / in_data to any output.
// -----------------------------------------------------------------------------
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CLK_DIV   = 1,
  parameter int LSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_busy,
  output logic             frame_done
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("par2ser_tx: WIDTH must be at least 1");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("par2ser_tx: CLK_DIV must be at least 1");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("par2ser_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
  end

  // Parity of the captured word: even parity makes the total count of ones
  // (data + parity) even, odd parity makes it odd.
  function automatic logic calc_parity(input logic [WIDTH-1:0] word);
    logic p;
    p = ^word;
    if (PARITY == PAR_ODD) begin
      p = ~p;
    end
    return p;
  endfunction

  // Move the next data bit into the output position.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] word);
    if (LSB_FIRST != 0) begin
      return word >> 1;
    end else begin
      return word << 1;
    end
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             par_bit;
  logic             run;
  logic             tick;
  logic             accept;
  logic             last_bit;
  logic             data_bit;

  assign run      = (state != IDLE);
  assign accept   = (state == IDLE) && in_valid;
  assign last_bit = (bit_cnt == BIT_LAST);
  assign data_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];

  ser_bit_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .run     (run),
    .tick    (tick)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = START;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (tick && last_bit) begin
          state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (tick) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    in_ready   = (state == IDLE);
    ser_busy   = (state != IDLE);
    frame_done = (state == STOP) && tick;
    ser_out    = 1'b1;
    unique case (state)
      IDLE:    ser_out = 1'b1;
      START:   ser_out = 1'b0;
      DATA:    ser_out = data_bit;
      PAR:     ser_out = par_bit;
      STOP:    ser_out = 1'b1;
      default: ser_out = 1'b1;
    endcase
  end

  // Word capture and shifting. The word is latched once at acceptance, so
  // later changes on in_data cannot disturb the frame in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else if (accept) begin
      shreg   <= in_data;
      par_bit <= calc_parity(in_data);
      bit_cnt <= '0;
    end else if ((state == DATA) && tick) begin
      shreg   <= shift_word(shreg);
      bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
    end
  end

endmodule : par2ser_tx

// File: tb/tb_par2ser_tx.sv
// -----------------------------------------------------------------------------
// tb_par2ser_tx
// Directed bench for par2ser_tx. Five instances cover the parameter sets:
//   0: base       WIDTH=4 CLK_DIV=1 LSB_FIRST=1 PARITY=0
//   1: div3       WIDTH=4 CLK_DIV=3 LSB_FIRST=1 PARITY=0
//   2: even       WIDTH=4 CLK_DIV=1 LSB_FIRST=1 PARITY=1
//   3: odd        WIDTH=4 CLK_DIV=1 LSB_FIRST=1 PARITY=2
//   4: msb first  WIDTH=4 CLK_DIV=1 LSB_FIRST=0 PARITY=0
// Inputs change and outputs are sampled on the falling edge. Expected serial
// sequences are packed with bit i = level in the i-th cycle after acceptance.
// -----------------------------------------------------------------------------
module tb_par2ser_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d    [5];
  logic       v    [5];
  logic       rdy  [5];
  logic       so   [5];
  logic       busy [5];
  logic       done [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  par2ser_tx #(.WIDTH(4), .CLK_DIV(1), .LSB_FIRST(1), .PARITY(0)) u_base (
    .sys_clk(clk), .sys_rst(rst), .in_data(d[0]), .in_valid(v[0]),
    .in_ready(rdy[0]), .ser_out(so[0]), .ser_busy(busy[0]), .frame_done(done[0]));

  par2ser_tx #(.WIDTH(4), .CLK_DIV(3), .LSB_FIRST(1), .PARITY(0)) u_div3 (
    .sys_clk(clk), .sys_rst(rst), .in_data(d[1]), .in_valid(v[1]),
    .in_ready(rdy[1]), .ser_out(so[1]), .ser_busy(busy[1]), .frame_done(done[1]));

  par2ser_tx #(.WIDTH(4), .CLK_DIV(1), .LSB_FIRST(1), .PARITY(1)) u_even (
    .sys_clk(clk), .sys_rst(rst), .in_data(d[2]), .in_valid(v[2]),
    .in_ready(rdy[2]), .ser_out(so[2]), .ser_busy(busy[2]), .frame_done(done[2]));

  par2ser_tx #(.WIDTH(4), .CLK_DIV(1), .LSB_FIRST(1), .PARITY(2)) u_odd (
    .sys_clk(clk), .sys_rst(rst), .in_data(d[3]), .in_valid(v[3]),
    .in_ready(rdy[3]), .ser_out(so[3]), .ser_busy(busy[3]), .frame_done(done[3]));

  par2ser_tx #(.WIDTH(4), .CLK_DIV(1), .LSB_FIRST(0), .PARITY(0)) u_msb (
    .sys_clk(clk), .sys_rst(rst), .in_data(d[4]), .in_valid(v[4]),
    .in_ready(rdy[4]), .ser_out(so[4]), .ser_busy(busy[4]), .frame_done(done[4]));

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (so[k] !== 1'b1 || rdy[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got so=%b rdy=%b busy=%b done=%b required so=1 rdy=1 busy=0 done=0",
                 k, so[k], rdy[k], busy[k], done[k]);
      end
    end
    // Reset together with a valid word: nothing may be captured.
    v[0] = 1'b1;
    d[0] = 4'hF;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || so[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_vs_valid: got busy=%b so=%b required busy=0 so=1", busy[0], so[0]);
    end
    v[0] = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_vs_valid_after: got busy=%b rdy=%b required busy=0 rdy=1", busy[0], rdy[0]);
    end
  endtask

  task automatic test_base_frame();
    logic [5:0] exp_so   = 6'b110110;
    logic [5:0] exp_done = 6'b100000;
    v[0] = 1'b1;
    d[0] = 4'b1011;
    @(negedge clk);
    v[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (so[0] !== exp_so[i] || done[0] !== exp_done[i] || busy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL base_frame[%0d]: got so=%b done=%b busy=%b rdy=%b required so=%b done=%b busy=1 rdy=0",
                 i, so[0], done[0], busy[0], rdy[0], exp_so[i], exp_done[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (rdy[0] !== 1'b1 || busy[0] !== 1'b0 || so[0] !== 1'b1) begin
      errors++;
      $display("FAIL base_frame_end: got rdy=%b busy=%b so=%b required rdy=1 busy=0 so=1",
               rdy[0], busy[0], so[0]);
    end
  endtask

  task automatic test_bit_hold();
    logic [5:0] lvl = 6'b101000;
    v[1] = 1'b1;
    d[1] = 4'b0100;
    @(negedge clk);
    v[1] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (so[1] !== lvl[i / 3] || busy[1] !== 1'b1 || done[1] !== (i == 17)) begin
        errors++;
        $display("FAIL bit_hold[%0d]: got so=%b busy=%b done=%b required so=%b busy=1 done=%b",
                 i, so[1], busy[1], done[1], lvl[i / 3], (i == 17));
      end
      @(negedge clk);
    end
    checks++;
    if (busy[1] !== 1'b0 || rdy[1] !== 1'b1 || so[1] !== 1'b1) begin
      errors++;
      $display("FAIL bit_hold_end: got busy=%b rdy=%b so=%b required busy=0 rdy=1 so=1",
               busy[1], rdy[1], so[1]);
    end
  endtask

  task automatic test_parity();
    logic [6:0] exp_even = 7'b1101110;
    logic [6:0] exp_odd  = 7'b1001110;
    v[2] = 1'b1; d[2] = 4'b0111;
    v[3] = 1'b1; d[3] = 4'b0111;
    @(negedge clk);
    v[2] = 1'b0;
    v[3] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (so[2] !== exp_even[i] || done[2] !== (i == 6)) begin
        errors++;
        $display("FAIL parity_even[%0d]: got so=%b done=%b required so=%b done=%b",
                 i, so[2], done[2], exp_even[i], (i == 6));
      end
      checks++;
      if (so[3] !== exp_odd[i] || done[3] !== (i == 6)) begin
        errors++;
        $display("FAIL parity_odd[%0d]: got so=%b done=%b required so=%b done=%b",
                 i, so[3], done[3], exp_odd[i], (i == 6));
      end
      @(negedge clk);
    end
    checks++;
    if (busy[2] !== 1'b0 || busy[3] !== 1'b0 || rdy[2] !== 1'b1 || rdy[3] !== 1'b1) begin
      errors++;
      $display("FAIL parity_end: got busy=%b/%b rdy=%b/%b required busy=0/0 rdy=1/1",
               busy[2], busy[3], rdy[2], rdy[3]);
    end
  endtask

  task automatic test_busy_ignore();
    logic [5:0] exp_so = 6'b100010;
    v[0] = 1'b1;
    d[0] = 4'b0001;
    @(negedge clk);
    v[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (so[0] !== exp_so[i]) begin
        errors++;
        $display("FAIL busy_ignore[%0d]: got so=%b required so=%b", i, so[0], exp_so[i]);
      end
      // Offer a new word during the first two data bits, then withdraw it.
      if (i == 1) begin
        v[0] = 1'b1;
        d[0] = 4'hF;
      end else if (i == 3) begin
        v[0] = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (so[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL busy_ignore_idle[%0d]: got so=%b busy=%b done=%b required so=1 busy=0 done=0",
                 i, so[0], busy[0], done[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_lsb  = 14'b11010101110100;
    logic [13:0] exp_msb  = 14'b11101001101010;
    logic [13:0] exp_busy = 14'b01111110111111;
    logic [13:0] exp_done = 14'b01000000100000;
    v[0] = 1'b1; d[0] = 4'hA;
    v[4] = 1'b1; d[4] = 4'hA;
    @(negedge clk);
    d[0] = 4'h5;
    d[4] = 4'h5;
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (so[0] !== exp_lsb[i] || busy[0] !== exp_busy[i] || done[0] !== exp_done[i]) begin
        errors++;
        $display("FAIL b2b_lsb[%0d]: got so=%b busy=%b done=%b required so=%b busy=%b done=%b",
                 i, so[0], busy[0], done[0], exp_lsb[i], exp_busy[i], exp_done[i]);
      end
      checks++;
      if (so[4] !== exp_msb[i] || busy[4] !== exp_busy[i] || done[4] !== exp_done[i]) begin
        errors++;
        $display("FAIL b2b_msb[%0d]: got so=%b busy=%b done=%b required so=%b busy=%b done=%b",
                 i, so[4], busy[4], done[4], exp_msb[i], exp_busy[i], exp_done[i]);
      end
      if (i == 7) begin
        v[0] = 1'b0;
        v[4] = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (busy[0] !== 1'b0 || busy[4] !== 1'b0 || rdy[0] !== 1'b1 || rdy[4] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b/%b rdy=%b/%b required busy=0/0 rdy=1/1",
               busy[0], busy[4], rdy[0], rdy[4]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [5:0] exp_so = 6'b101100;
    v[0] = 1'b1;
    d[0] = 4'b1011;
    @(negedge clk);
    v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Second data bit of 4'b1011 (LSB first) is 1.
    checks++;
    if (so[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_pre: got so=%b busy=%b required so=1 busy=1", so[0], busy[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (so[0] !== 1'b1 || rdy[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got so=%b rdy=%b busy=%b done=%b required so=1 rdy=1 busy=0 done=0",
               so[0], rdy[0], busy[0], done[0]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b0 || so[0] !== 1'b1 || busy[0] !== 1'b0) begin
        errors++;
        $display("FAIL midframe_quiet[%0d]: got done=%b so=%b busy=%b required done=0 so=1 busy=0",
                 i, done[0], so[0], busy[0]);
      end
    end
    v[0] = 1'b1;
    d[0] = 4'b0110;
    @(negedge clk);
    v[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (so[0] !== exp_so[i] || done[0] !== (i == 5)) begin
        errors++;
        $display("FAIL midframe_clean[%0d]: got so=%b done=%b required so=%b done=%b",
                 i, so[0], done[0], exp_so[i], (i == 5));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      v[k] = 1'b0;
      d[k] = 4'h0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_base_frame();
    test_bit_hold();
    test_parity();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_par2ser_tx
